// File: rtl/pe_stream_feeder_pkg.sv
// Shared types and constants for the PE stream feeder: widths, config field
// slices, stream tags, FSM and read-sequencer encodings.
package pe_stream_feeder_pkg;
  localparam int DATA_BITS   = 32;
  localparam int ADDR_W      = 16;
  localparam int CONFIG_SIZE = 12;

  typedef enum logic [1:0] {TAG_FLT, TAG_IFM, TAG_IPS} tag_e;
  typedef enum logic [1:0] {S_IDLE, S_CFG, S_RUN, S_DONE} state_e;
  typedef enum logic [2:0] {PH_FLT, PH_IFM0, PH_IPS, PH_IF1, PH_END} phase_e;

  function automatic logic [1:0] cfg_fld_p(input logic [CONFIG_SIZE-1:0] c);
    return c[11:10];
  endfunction

  function automatic logic [1:0] cfg_fld_q(input logic [CONFIG_SIZE-1:0] c);
    return c[9:8];
  endfunction

  function automatic logic [7:0] cfg_fld_f(input logic [CONFIG_SIZE-1:0] c);
    return c[7:0];
  endfunction

  // Filter words per pass: 3 taps for each of P+1 rows.
  function automatic logic [3:0] flt_words(input logic [1:0] p);
    return 4'(3 * ({2'b00, p} + 4'd1));
  endfunction

  function automatic logic [ADDR_W-1:0] opsum_total(input logic [CONFIG_SIZE-1:0] c);
    return (ADDR_W'(cfg_fld_f(c)) + ADDR_W'(1)) * (ADDR_W'(cfg_fld_p(c)) + ADDR_W'(1));
  endfunction
endpackage

// File: rtl/pe_stream_feeder_if.sv
// GLB read/write bus plus the PE-facing stream handshakes.
// master = feeder side, slave = GLB/PE side.
interface pe_stream_feeder_if;
  import pe_stream_feeder_pkg::*;

  logic                   glb_rd_en;
  logic [ADDR_W-1:0]      glb_rd_addr;
  logic [DATA_BITS-1:0]   glb_rd_data;
  logic                   glb_wr_en;
  logic [ADDR_W-1:0]      glb_wr_addr;
  logic [DATA_BITS-1:0]   glb_wr_data;
  logic                   PE_en;
  logic [CONFIG_SIZE-1:0] o_config;
  logic [DATA_BITS-1:0]   filter, ifmap, ipsum;
  logic                   filter_valid, ifmap_valid, ipsum_valid;
  logic                   filter_ready, ifmap_ready, ipsum_ready;
  logic [DATA_BITS-1:0]   opsum;
  logic                   opsum_valid;
  logic                   opsum_ready;

  modport master (
    output glb_rd_en, glb_rd_addr, input glb_rd_data,
    output glb_wr_en, glb_wr_addr, glb_wr_data,
    output PE_en, o_config, filter, ifmap, ipsum,
    output filter_valid, ifmap_valid, ipsum_valid,
    input  filter_ready, ifmap_ready, ipsum_ready,
    input  opsum, opsum_valid, output opsum_ready
  );

  modport slave (
    input  glb_rd_en, glb_rd_addr, output glb_rd_data,
    input  glb_wr_en, glb_wr_addr, glb_wr_data,
    input  PE_en, o_config, filter, ifmap, ipsum,
    input  filter_valid, ifmap_valid, ipsum_valid,
    output filter_ready, ifmap_ready, ipsum_ready,
    output opsum, opsum_valid, input opsum_ready
  );
endinterface

// File: rtl/pe_stream_feeder_fifo2.sv
// Two-entry tagged FIFO holding GLB words on their way to the PE.
module pe_feed_fifo2
  import pe_stream_feeder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  tag_e                 push_tag,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [1:0]           count,
  output tag_e                 head_tag,
  output logic [DATA_BITS-1:0] head_data
);
  logic [1:0][DATA_BITS-1:0] data_q, data_d;
  logic [1:0][1:0]           tag_q, tag_d;
  logic                      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]                count_q, count_d;
  logic                      do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    // At full, the push lands in the slot being popped; the pop still sees the old word.
    do_push  = push && ((count_q != 2'd2) || do_pop);
    data_d   = data_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      data_d[wr_ptr_q] = push_data;
      tag_d[wr_ptr_q]  = push_tag;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      tag_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      data_q   <= data_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count     = count_q;
  assign head_tag  = tag_e'(tag_q[rd_ptr_q]);
  assign head_data = data_q[rd_ptr_q];
endmodule

// File: rtl/pe_stream_feeder.sv
// PE stream initiator: sequences filter/ifmap/ipsum reads from the GLB into the
// PE in consumption order and writes returned opsums back to the GLB.
module pe_stream_feeder
  import pe_stream_feeder_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CONFIG_SIZE-1:0] cfg,
  input  logic [ADDR_W-1:0]      filter_base,
  input  logic [ADDR_W-1:0]      ifmap_base,
  input  logic [ADDR_W-1:0]      ipsum_base,
  input  logic [ADDR_W-1:0]      opsum_base,
  output logic                   busy,
  output logic                   done,
  pe_stream_feeder_if.master     bus
);
  state_e                 state_q, state_d;
  logic                   busy_q, busy_d, done_q, done_d, pe_en_q, pe_en_d, ordy_q, ordy_d;
  logic [CONFIG_SIZE-1:0] cfg_q, cfg_d;
  phase_e                 phase_q, phase_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [7:0]             col_q, col_d;
  logic [ADDR_W-1:0]      ips_ptr_q, ips_ptr_d, opsum_cnt_q, opsum_cnt_d;
  logic                   inflight_q;
  tag_e                   inflight_tag_q;

  logic                   rd_en, wr_en, pop;
  logic [ADDR_W-1:0]      rd_addr;
  tag_e                   rd_tag, head_tag;
  logic [1:0]             fifo_count;
  logic [DATA_BITS-1:0]   head_data;
  logic                   flt_vld, ifm_vld, ips_vld;

  pe_feed_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_tag  (inflight_tag_q),
    .push_data (bus.glb_rd_data),
    .pop       (pop),
    .count     (fifo_count),
    .head_tag  (head_tag),
    .head_data (head_data)
  );

  assign flt_vld = (fifo_count != 2'd0) && (head_tag == TAG_FLT);
  assign ifm_vld = (fifo_count != 2'd0) && (head_tag == TAG_IFM);
  assign ips_vld = (fifo_count != 2'd0) && (head_tag == TAG_IPS);
  assign pop     = (flt_vld && bus.filter_ready) || (ifm_vld && bus.ifmap_ready) ||
                   (ips_vld && bus.ipsum_ready);

  // Words still queued or on their way back count against the two FIFO slots.
  assign rd_en = (state_q == S_RUN) && (phase_q != PH_END) &&
                 (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2);
  assign wr_en = bus.opsum_valid && ordy_q;

  always_comb begin
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    ips_ptr_d   = ips_ptr_q;
    opsum_cnt_d = opsum_cnt_q;
    rd_addr     = '0;
    rd_tag      = TAG_FLT;
    case (phase_q)
      PH_FLT:  begin rd_addr = filter_base + ADDR_W'(cnt_q); rd_tag = TAG_FLT; end
      PH_IFM0: begin rd_addr = ifmap_base + ADDR_W'(cnt_q);  rd_tag = TAG_IFM; end
      PH_IPS:  begin rd_addr = ipsum_base + ips_ptr_q;       rd_tag = TAG_IPS; end
      PH_IF1:  begin rd_addr = ifmap_base + ADDR_W'(col_q) + ADDR_W'(3); rd_tag = TAG_IFM; end
      default: ;
    endcase
    if (rd_en) begin
      case (phase_q)
        PH_FLT:
          if (cnt_q == flt_words(cfg_fld_p(cfg_q)) - 4'd1) begin
            phase_d = PH_IFM0;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 4'd1;
        PH_IFM0:
          if (cnt_q == 4'd2) begin
            phase_d = PH_IPS;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 4'd1;
        PH_IPS: begin
          // ipsum words of consecutive columns are contiguous, so one pointer covers f(P+1)+p.
          ips_ptr_d = ips_ptr_q + ADDR_W'(1);
          if (cnt_q == {2'b00, cfg_fld_p(cfg_q)}) begin
            cnt_d   = '0;
            phase_d = (col_q == cfg_fld_f(cfg_q)) ? PH_END : PH_IF1;
          end else cnt_d = cnt_q + 4'd1;
        end
        PH_IF1: begin
          col_d   = col_q + 8'd1;
          phase_d = PH_IPS;
        end
        default: ;
      endcase
    end
    if (wr_en) opsum_cnt_d = opsum_cnt_q + ADDR_W'(1);
    if (state_q == S_CFG) begin
      phase_d     = PH_FLT;
      cnt_d       = '0;
      col_d       = '0;
      ips_ptr_d   = '0;
      opsum_cnt_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_CFG;
        cfg_d   = cfg;
      end
      S_CFG:  state_d = S_RUN;
      S_RUN:  if (wr_en && (opsum_cnt_q + ADDR_W'(1) == opsum_total(cfg_q))) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    pe_en_d = (state_d == S_CFG);
    ordy_d  = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pe_en_q        <= 1'b0;
      ordy_q         <= 1'b0;
      cfg_q          <= '0;
      phase_q        <= PH_FLT;
      cnt_q          <= '0;
      col_q          <= '0;
      ips_ptr_q      <= '0;
      opsum_cnt_q    <= '0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= TAG_FLT;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pe_en_q        <= pe_en_d;
      ordy_q         <= ordy_d;
      cfg_q          <= cfg_d;
      phase_q        <= phase_d;
      cnt_q          <= cnt_d;
      col_q          <= col_d;
      ips_ptr_q      <= ips_ptr_d;
      opsum_cnt_q    <= opsum_cnt_d;
      inflight_q     <= rd_en;
      inflight_tag_q <= rd_tag;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign bus.glb_rd_en    = rd_en;
  assign bus.glb_rd_addr  = rd_en ? rd_addr : '0;
  assign bus.glb_wr_en    = wr_en;
  assign bus.glb_wr_addr  = wr_en ? (opsum_base + opsum_cnt_q) : '0;
  assign bus.glb_wr_data  = wr_en ? bus.opsum : '0;
  assign bus.PE_en        = pe_en_q;
  assign bus.o_config     = cfg_q;
  assign bus.filter       = head_data;
  assign bus.ifmap        = head_data;
  assign bus.ipsum        = head_data;
  assign bus.filter_valid = flt_vld;
  assign bus.ifmap_valid  = ifm_vld;
  assign bus.ipsum_valid  = ips_vld;
  assign bus.opsum_ready  = ordy_q;
endmodule

// File: tb/tb_pe_stream_feeder.sv
// Directed bench for pe_stream_feeder with a GLB memory model, a PE model and
// scoreboard queues for stream words and opsum writes.
module tb_pe_stream_feeder;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [11:0] cfg;
  logic [15:0] filter_base, ifmap_base, ipsum_base, opsum_base;
  logic        busy, done;

  pe_stream_feeder_if bus();

  pe_stream_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg(cfg),
    .filter_base(filter_base), .ifmap_base(ifmap_base),
    .ipsum_base(ipsum_base), .opsum_base(opsum_base),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_assert = 0, n_fail = 0, cyc = 0;
  int          exp_tag_q[$];
  logic [31:0] exp_dat_q[$];
  logic [15:0] exp_waddr_q[$];
  logic [31:0] exp_wdat_q[$];
  logic [31:0] pe_q[$];
  bit          pend, bp, hold, first_rd_seen;
  logic [15:0] pend_addr, first_rd, obase_r;
  logic [2:0]  hold_vld;
  logic [31:0] hold_dat, op_seed;
  int          pe_en_cnt, done_cnt, last_wr_cyc, done_cyc, op_idx;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic outs_nonzero();
    return |{busy, done, bus.glb_rd_en, bus.glb_rd_addr, bus.glb_wr_en, bus.glb_wr_addr,
             bus.glb_wr_data, bus.PE_en, bus.o_config, bus.filter, bus.ifmap, bus.ipsum,
             bus.filter_valid, bus.ifmap_valid, bus.ipsum_valid, bus.opsum_ready};
  endfunction

  // One clock: drive GLB/PE responses after the edge, observe on the falling edge.
  task automatic tick();
    logic [2:0]  vld;
    logic        xfer;
    int          otag, et;
    logic [31:0] odat, ed;
    @(posedge clk); #1;
    bus.glb_rd_data  = pend ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    bus.filter_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.ifmap_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.ipsum_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.opsum_valid  = (pe_q.size() != 0);
    bus.opsum        = (pe_q.size() != 0) ? pe_q[0] : 32'h0;
    @(negedge clk);
    cyc++;
    vld = {bus.filter_valid, bus.ifmap_valid, bus.ipsum_valid};
    chk("valid_onehot", 64'($countones(vld) <= 1), 64'd1);
    if (hold) begin
      chk("hold_valid", 64'(vld), 64'(hold_vld));
      chk("hold_data", 64'(bus.filter), 64'(hold_dat));
    end
    xfer = (bus.filter_valid && bus.filter_ready) || (bus.ifmap_valid && bus.ifmap_ready) ||
           (bus.ipsum_valid && bus.ipsum_ready);
    if (xfer) begin
      otag = bus.filter_valid ? 0 : (bus.ifmap_valid ? 1 : 2);
      odat = (otag == 0) ? bus.filter : ((otag == 1) ? bus.ifmap : bus.ipsum);
      if (exp_tag_q.size() == 0) chk("extra_word", 64'(odat), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        et = exp_tag_q.pop_front();
        ed = exp_dat_q.pop_front();
        chk("word_tag", 64'(otag), 64'(et));
        chk("word_data", 64'(odat), 64'(ed));
        if (otag == 2) begin
          pe_q.push_back(op_seed + 32'(op_idx));
          exp_waddr_q.push_back(16'(obase_r + 16'(op_idx)));
          exp_wdat_q.push_back(op_seed + 32'(op_idx));
          op_idx++;
        end
      end
    end
    hold     = (vld != 3'b000) && !xfer;
    hold_vld = vld;
    hold_dat = bus.filter;
    if (bus.glb_wr_en) begin
      if (exp_waddr_q.size() == 0) chk("extra_write", 64'(bus.glb_wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        chk("wr_addr", 64'(bus.glb_wr_addr), 64'(exp_waddr_q.pop_front()));
        chk("wr_data", 64'(bus.glb_wr_data), 64'(exp_wdat_q.pop_front()));
      end
      last_wr_cyc = cyc;
    end
    if (bus.opsum_valid && bus.opsum_ready) void'(pe_q.pop_front());
    if (bus.glb_rd_en) begin
      pend      = 1'b1;
      pend_addr = bus.glb_rd_addr;
      if (!first_rd_seen) begin first_rd = bus.glb_rd_addr; first_rd_seen = 1'b1; end
    end else pend = 1'b0;
    if (bus.PE_en) pe_en_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
  endtask

  task automatic clear_model();
    exp_tag_q.delete(); exp_dat_q.delete(); exp_waddr_q.delete(); exp_wdat_q.delete();
    pe_q.delete();
    pend = 1'b0; hold = 1'b0; first_rd_seen = 1'b0;
    pe_en_cnt = 0; done_cnt = 0; op_idx = 0; last_wr_cyc = -10; done_cyc = -20;
  endtask

  task automatic push_rd(input int tag, input logic [15:0] a);
    exp_tag_q.push_back(tag);
    exp_dat_q.push_back(mem_word(a));
  endtask

  task automatic setup_pass(input int p, input int f, input logic [15:0] ob, input logic [31:0] seed);
    clear_model();
    cfg        = {2'(p), 2'b01, 8'(f)};
    opsum_base = ob;
    obase_r    = ob;
    op_seed    = seed;
    for (int k = 0; k < 3 * (p + 1); k++) push_rd(0, 16'(filter_base + 16'(k)));
    for (int k = 0; k < 3; k++) push_rd(1, 16'(ifmap_base + 16'(k)));
    for (int c = 0; c <= f; c++) begin
      for (int q = 0; q <= p; q++) push_rd(2, 16'(ipsum_base + 16'(c * (p + 1) + q)));
      if (c < f) push_rd(1, 16'(ifmap_base + 16'(c + 3)));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_pass(input int p, input int f, input logic [15:0] ob, input logic [31:0] seed,
                          input bit bp_i, input bit poke);
    logic [11:0] latched;
    int          n;
    bp = bp_i;
    setup_pass(p, f, ob, seed);
    latched = cfg;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      if (poke && n == 20) begin start = 1'b1; cfg = 12'hFFF; end
      if (poke && n == 21) start = 1'b0;
      tick();
      n++;
      if (poke && n == 22) chk("o_config_held", 64'(bus.o_config), 64'(latched));
    end
    chk("done_seen", 64'(done_cnt), 64'd1);
    chk("done_after_last_wr", 64'(done_cyc), 64'(last_wr_cyc + 1));
    tick();
    chk("busy_cleared", 64'(busy), 64'd0);
    chk("pe_en_once", 64'(pe_en_cnt), 64'd1);
    chk("words_left", 64'(exp_tag_q.size()), 64'd0);
    chk("writes_left", 64'(exp_waddr_q.size()), 64'd0);
    chk("first_rd_addr", 64'(first_rd), 64'(filter_base));
    chk("o_config_end", 64'(bus.o_config), 64'(latched));
    bp = 1'b0;
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; cfg = '0; bp = 1'b0;
    filter_base = 16'h1000; ifmap_base = 16'h2000; ipsum_base = 16'h3000; opsum_base = 16'h4000;
    bus.glb_rd_data = '0; bus.filter_ready = 1'b0; bus.ifmap_ready = 1'b0; bus.ipsum_ready = 1'b0;
    bus.opsum = '0; bus.opsum_valid = 1'b0;
    clear_model();
    tick(); tick();
    chk("reset_outputs", 64'(outs_nonzero()), 64'd0);
    rst_n = 1'b1;
    tick();

    // P=0, F=0: PE returns 5, single write at opsum_base
    run_pass(0, 0, 16'h4000, 32'h5, 1'b0, 1'b0);
    // P=3, F=2 with all readys high
    run_pass(3, 2, 16'h4100, 32'h100, 1'b0, 1'b0);
    // Same pass under random backpressure
    run_pass(3, 2, 16'h4200, 32'h200, 1'b1, 1'b0);
    // Start and cfg poked mid-pass
    run_pass(3, 2, 16'h4300, 32'h300, 1'b0, 1'b1);

    // Reset during column-1 ipsum phase
    bp = 1'b0;
    setup_pass(3, 2, 16'h4400, 32'h400);
    n = 0;
    while (op_idx < 5 && n < 3000) begin tick(); n++; end
    chk("reached_col1_ips", 64'(op_idx >= 5), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_async", 64'(outs_nonzero()), 64'd0);
    clear_model();
    tick();
    chk("abort_outputs_edge", 64'(outs_nonzero()), 64'd0);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    rst_n = 1'b1;
    clear_model();
    tick();
    run_pass(0, 1, 16'h4500, 32'h500, 1'b0, 1'b0);

    // Write address wraps past 0xFFFF
    run_pass(1, 1, 16'hFFFE, 32'h600, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
